// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and arctangent table for the Q10/Q14 CORDIC.
package cordic_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 4;

  localparam logic signed [DATA_W-1:0] CORDIC_GAIN_Q14 = 32'sd9949;
  localparam logic signed [DATA_W-1:0] PI_Q10          = 32'sd3217;
  localparam logic signed [DATA_W-1:0] HALF_PI_Q10     = 32'sd1608;
  localparam logic signed [DATA_W-1:0] QUARTER_PI_Q10  = 32'sd804;
  localparam logic signed [DATA_W-1:0] PI_Q14          = 32'sd51472;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_FINISH = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // atan(2^-i) in Q14 radians
  function automatic logic signed [DATA_W-1:0] atan_q14(input logic [IDX_W-1:0] idx);
    logic signed [DATA_W-1:0] val;
    case (idx)
      4'd0:    val = 32'sd12868;
      4'd1:    val = 32'sd7596;
      4'd2:    val = 32'sd4014;
      4'd3:    val = 32'sd2037;
      4'd4:    val = 32'sd1023;
      4'd5:    val = 32'sd512;
      4'd6:    val = 32'sd256;
      4'd7:    val = 32'sd128;
      4'd8:    val = 32'sd64;
      4'd9:    val = 32'sd32;
      4'd10:   val = 32'sd16;
      4'd11:   val = 32'sd8;
      4'd12:   val = 32'sd4;
      4'd13:   val = 32'sd2;
      4'd14:   val = 32'sd1;
      default: val = 32'sd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cordic_step.sv
// One combinational CORDIC micro-rotation (rotation mode).
module cordic_step
  import cordic_pkg::*;
(
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y,
  input  logic signed [DATA_W-1:0] z,
  input  logic        [IDX_W-1:0]  shift,
  input  logic signed [DATA_W-1:0] atan,
  output logic signed [DATA_W-1:0] x_next,
  output logic signed [DATA_W-1:0] y_next,
  output logic signed [DATA_W-1:0] z_next
);

  // Rotate toward z = 0; direction chosen by the sign of the residual angle
  always_comb begin
    x_next = x;
    y_next = y;
    z_next = z;
    if (z >= 0) begin
      x_next = x - (y >>> shift);
      y_next = y + (x >>> shift);
      z_next = z - atan;
    end else begin
      x_next = x + (y >>> shift);
      y_next = y - (x >>> shift);
      z_next = z + atan;
    end
  end

endmodule

// File: rtl/qsincos.sv
// Quadrant-folded iterative CORDIC: Q10 radian angle in, Q10 cos/sin out.
module qsincos
  import cordic_pkg::*;
#(
  parameter int unsigned ITERATIONS = 16,
  parameter int unsigned IN_FRAC    = 10,
  parameter int unsigned INT_FRAC   = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     angle_valid,
  input  logic signed [DATA_W-1:0] angle_in,
  output logic                     ready,
  output logic signed [DATA_W-1:0] cos_out,
  output logic signed [DATA_W-1:0] sin_out,
  output logic                     done
);

  localparam int unsigned FRAC_SHIFT = INT_FRAC - IN_FRAC;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITERATIONS - 1);
  localparam logic signed [DATA_W-1:0] ROUND_ADD = DATA_W'((1 << FRAC_SHIFT) - 1);

  state_t state, state_n;

  logic signed [DATA_W-1:0] x_q, y_q, z_q;
  logic signed [DATA_W-1:0] x_n, y_n, z_n;
  logic        [IDX_W-1:0]  idx_q, idx_n;
  logic                     flip_q, flip_n;
  logic signed [DATA_W-1:0] cos_n, sin_n;
  logic                     done_n, ready_n;

  logic signed [DATA_W-1:0] angle_sat, angle_scaled;
  logic signed [DATA_W-1:0] step_x, step_y, step_z;
  logic signed [DATA_W-1:0] x_fin, y_fin;

  // Clamp to +/-pi and move to the internal fraction width
  assign angle_sat = (angle_in > PI_Q10)  ? PI_Q10 :
                     (angle_in < -PI_Q10) ? -PI_Q10 : angle_in;
  assign angle_scaled = angle_sat <<< FRAC_SHIFT;

  // Undo the quadrant fold before rescaling
  assign x_fin = flip_q ? -x_q : x_q;
  assign y_fin = flip_q ? -y_q : y_q;

  cordic_step u_step (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .shift  (idx_q),
    .atan   (atan_q14(idx_q)),
    .x_next (step_x),
    .y_next (step_y),
    .z_next (step_z)
  );

  // Next-state and datapath update
  always_comb begin
    state_n = state;
    x_n     = x_q;
    y_n     = y_q;
    z_n     = z_q;
    idx_n   = idx_q;
    flip_n  = flip_q;
    cos_n   = cos_out;
    sin_n   = sin_out;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (angle_valid) begin
          x_n   = CORDIC_GAIN_Q14;
          y_n   = '0;
          idx_n = '0;
          if (angle_sat > HALF_PI_Q10) begin
            z_n    = angle_scaled - PI_Q14;
            flip_n = 1'b1;
          end else if (angle_sat < -HALF_PI_Q10) begin
            z_n    = angle_scaled + PI_Q14;
            flip_n = 1'b1;
          end else begin
            z_n    = angle_scaled;
            flip_n = 1'b0;
          end
          state_n = ST_ROTATE;
        end
      end
      ST_ROTATE: begin
        x_n   = step_x;
        y_n   = step_y;
        z_n   = step_z;
        idx_n = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_n = ST_FINISH;
      end
      ST_FINISH: begin
        // Truncate toward zero when dropping the extra fraction bits
        cos_n   = (x_fin < 0) ? ((x_fin + ROUND_ADD) >>> FRAC_SHIFT) : (x_fin >>> FRAC_SHIFT);
        sin_n   = (y_fin < 0) ? ((y_fin + ROUND_ADD) >>> FRAC_SHIFT) : (y_fin >>> FRAC_SHIFT);
        done_n  = 1'b1;
        state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    ready_n = (state_n == ST_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      idx_q   <= '0;
      flip_q  <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
      done    <= 1'b0;
      ready   <= 1'b1;
    end else begin
      state   <= state_n;
      x_q     <= x_n;
      y_q     <= y_n;
      z_q     <= z_n;
      idx_q   <= idx_n;
      flip_q  <= flip_n;
      cos_out <= cos_n;
      sin_out <= sin_n;
      done    <= done_n;
      ready   <= ready_n;
    end
  end

endmodule

// File: tb/tb_qsincos.sv
// Directed self-checking bench for qsincos.
module tb_qsincos;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               angle_valid = 1'b0;
  logic signed [31:0] angle_in = '0;
  logic               ready;
  logic signed [31:0] cos_out;
  logic signed [31:0] sin_out;
  logic               done;

  int checks   = 0;
  int failures = 0;

  logic signed [31:0] prev_cos = '0;
  logic signed [31:0] prev_sin = '0;

  always #5 clk = ~clk;

  qsincos dut (
    .clk         (clk),
    .reset       (reset),
    .angle_valid (angle_valid),
    .angle_in    (angle_in),
    .ready       (ready),
    .cos_out     (cos_out),
    .sin_out     (sin_out),
    .done        (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input logic signed [31:0] obs, input int lo, input int hi);
    checks++;
    assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic int clamp(input int a);
    if (a > 3217) return 3217;
    if (a < -3217) return -3217;
    return a;
  endfunction

  function automatic int model_cos(input int a);
    real r;
    r = $cos(real'(clamp(a)) / 1024.0) * 1024.0;
    return $rtoi($floor(r + 0.5));
  endfunction

  function automatic int model_sin(input int a);
    real r;
    r = $sin(real'(clamp(a)) / 1024.0) * 1024.0;
    return $rtoi($floor(r + 0.5));
  endfunction

  // One transaction: returns outputs captured in the done cycle, then steps back to idle
  task automatic run(input string tag, input int a, output logic signed [31:0] c, output logic signed [31:0] s);
    int lat;
    angle_in    = a;
    angle_valid = 1'b1;
    tick;
    angle_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      tick;
      lat++;
    end
    check_eq({tag, "_done"}, 32'(done), 32'sd1);
    check_eq({tag, "_latency"}, lat, 18);
    check_eq({tag, "_ready_in_done"}, 32'(ready), 32'sd0);
    c = cos_out;
    s = sin_out;
    tick;
    check_eq({tag, "_ready_after"}, 32'(ready), 32'sd1);
    check_eq({tag, "_done_after"}, 32'(done), 32'sd0);
  endtask

  // Outputs may only move in the done cycle (or under reset)
  always @(negedge clk) begin
    if (reset === 1'b0 && done !== 1'b1) begin
      checks++;
      assert ((cos_out === prev_cos) && (sin_out === prev_sin)) else begin
        failures++;
        $error("FAIL stable observed=%0d/%0d expected=%0d/%0d", cos_out, sin_out, prev_cos, prev_sin);
      end
    end
    prev_cos = cos_out;
    prev_sin = sin_out;
  end

  initial begin
    logic signed [31:0] c, s, c_pi, s_pi;
    int seen_done;
    int acc;

    // Reset state
    repeat (3) tick;
    check_eq("rst_ready", 32'(ready), 32'sd1);
    check_eq("rst_done", 32'(done), 32'sd0);
    check_eq("rst_cos", cos_out, 32'sd0);
    check_eq("rst_sin", sin_out, 32'sd0);
    reset = 1'b0;
    tick;

    // Zero angle
    run("a0", 0, c, s);
    check_rng("a0_cos", c, 1022, 1026);
    check_rng("a0_sin", s, -2, 2);

    // pi/4
    run("a804", 804, c, s);
    check_rng("a804_cos", c, 722, 726);
    check_rng("a804_sin", s, 722, 726);

    // -3pi/4: negative fold with flip
    run("am2412", -2412, c, s);
    check_rng("am2412_cos", c, -726, -722);
    check_rng("am2412_sin", s, -726, -722);

    // pi/2 boundary, not folded
    run("a1608", 1608, c, s);
    check_rng("a1608_cos", c, -2, 2);
    check_rng("a1608_sin", s, 1022, 1026);

    // -pi/2 boundary, not folded
    run("am1608", -1608, c, s);
    check_rng("am1608_cos", c, -2, 2);
    check_rng("am1608_sin", s, -1026, -1022);

    // pi, folds to z = 0
    run("a3217", 3217, c_pi, s_pi);
    check_rng("a3217_cos", c_pi, -1026, -1022);
    check_rng("a3217_sin", s_pi, -2, 2);

    // Saturation: must reproduce the pi result
    run("a5000", 5000, c, s);
    check_rng("a5000_cos", c, -1026, -1022);
    check_eq("a5000_cos_eq_pi", c, c_pi);
    check_eq("a5000_sin_eq_pi", s, s_pi);

    // Continuous valid: only angles seen while idle are processed, one every 19 cycles
    for (int k = 0; k < 56; k++) begin
      angle_in    = -3000 + k * 97;
      angle_valid = 1'b1;
      tick;
      check_eq("cont_done", 32'(done), ((k % 19) == 17) ? 32'sd1 : 32'sd0);
      if ((k % 19) == 17) begin
        acc = -3000 + (k - 17) * 97;
        check_rng("cont_cos", cos_out, model_cos(acc) - 2, model_cos(acc) + 2);
        check_rng("cont_sin", sin_out, model_sin(acc) - 2, model_sin(acc) + 2);
      end
    end
    angle_valid = 1'b0;
    tick;

    // Reset mid-transaction
    angle_in    = 2000;
    angle_valid = 1'b1;
    tick;
    angle_valid = 1'b0;
    repeat (4) tick;
    #1 reset = 1'b1;
    #1;
    check_eq("midrst_ready", 32'(ready), 32'sd1);
    check_eq("midrst_done", 32'(done), 32'sd0);
    check_eq("midrst_cos", cos_out, 32'sd0);
    check_eq("midrst_sin", sin_out, 32'sd0);
    repeat (2) tick;
    reset = 1'b0;
    seen_done = 0;
    repeat (30) begin
      tick;
      if (done === 1'b1) seen_done = 1;
    end
    check_eq("midrst_no_done", seen_done, 0);
    run("post_rst", 804, c, s);
    check_rng("post_rst_cos", c, 722, 726);
    check_rng("post_rst_sin", s, 722, 726);

    // Sweep against a real-valued model
    for (int a = -3217; a <= 3217; a += 7) begin
      run("sweep", a, c, s);
      check_rng("sweep_cos", c, model_cos(a) - 2, model_cos(a) + 2);
      check_rng("sweep_sin", s, model_sin(a) - 2, model_sin(a) + 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
